axi4lite_slave: RTL and testbench

AXI4-Lite slave endpoint backed by a word-addressed, byte-writable memory. It terminates the slave side of an AXI4-Lite link: it accepts single-beat writes and reads from a master and returns write responses and read data. It sits wherever the bench or SoC needs a memory-mapped target behind an AXI4-Lite master.

---
 rtl/axi4lite_pkg.sv | 21 ++
 rtl/axi4lite_if.sv | 35 +++
 rtl/axi4lite_bram.sv | 47 ++++
 rtl/axi4lite_slave.sv | 183 ++++++++++++++++++
 tb/tb_axi4lite_slave.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4lite_pkg.sv
// Shared constants, default widths and FSM state types for the AXI4-Lite slave.
package axi4lite_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned MEM_DEPTH_DEF  = 1024;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4lite_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4lite_if #(
  parameter int unsigned ADDR_WIDTH = axi4lite_pkg::ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = axi4lite_pkg::DATA_WIDTH_DEF
) ();

  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4lite_bram.sv
// Single-clock word memory: byte-enable write port, registered read port.
// Read and write on the same edge to the same word returns the pre-write data.
module axi4lite_bram
  import axi4lite_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
  parameter int unsigned MEM_AW     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_we,
  input  logic [MEM_AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
  input  logic                      i_re,
  input  logic                      i_rzero,
  input  logic [MEM_AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0]     o_rdata
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
  end

  // i_rzero loads zero instead of memory for out-of-range reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4lite_slave.sv
// AXI4-Lite slave endpoint: independent write and read channel FSMs in front
// of a byte-writable word memory, with out-of-range addresses answered SLVERR.
module axi4lite_slave
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst,
  axi4lite_if.slave s_axi
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;
  localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  wr_state_e             r_wstate, w_wstate_nxt;
  logic                  r_aw_cap, r_w_cap, w_aw_cap_nxt, w_w_cap_nxt;
  logic                  r_awready, r_wready, r_bvalid;
  logic                  w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
  logic [1:0]            r_bresp, w_bresp_nxt;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]     r_wstrb;
  logic                  w_commit;

  rd_state_e             r_rstate, w_rstate_nxt;
  logic                  r_arready, r_rvalid;
  logic                  w_arready_nxt, w_rvalid_nxt;
  logic [1:0]            r_rresp, w_rresp_nxt;

  logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic [IDX_W-1:0]      w_wr_idx, w_rd_idx;
  logic [DATA_WIDTH-1:0] w_wr_data, w_bram_rdata;
  logic [STRB_W-1:0]     w_wr_strb;
  logic                  w_wr_in_range, w_rd_in_range;
  logic                  w_unused_addr_lsbs;

  assign w_aw_hs = s_axi.awvalid & r_awready;
  assign w_w_hs  = s_axi.wvalid  & r_wready;
  assign w_b_hs  = r_bvalid      & s_axi.bready;
  assign w_ar_hs = s_axi.arvalid & r_arready;
  assign w_r_hs  = r_rvalid      & s_axi.rready;

  // A same-cycle handshake bypasses the capture registers.
  assign w_wr_idx  = w_aw_hs ? s_axi.awaddr[ADDR_WIDTH-1:OFFS_W] : r_aw_idx;
  assign w_wr_data = w_w_hs  ? s_axi.wdata : r_wdata;
  assign w_wr_strb = w_w_hs  ? s_axi.wstrb : r_wstrb;
  assign w_rd_idx  = s_axi.araddr[ADDR_WIDTH-1:OFFS_W];

  assign w_wr_in_range = (w_wr_idx < IDX_W'(MEM_DEPTH));
  assign w_rd_in_range = (w_rd_idx < IDX_W'(MEM_DEPTH));

  assign w_unused_addr_lsbs = ^{s_axi.awaddr[OFFS_W-1:0], s_axi.araddr[OFFS_W-1:0]};

  // Address/data capture for whichever of AW/W arrives first.
  always_ff @(posedge clk) begin
    if (w_aw_hs) r_aw_idx <= s_axi.awaddr[ADDR_WIDTH-1:OFFS_W];
    if (w_w_hs) begin
      r_wdata <= s_axi.wdata;
      r_wstrb <= s_axi.wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_aw_cap  <= 1'b0;
      r_w_cap   <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_cap  <= w_aw_cap_nxt;
      r_w_cap   <= w_w_cap_nxt;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      r_bresp   <= w_bresp_nxt;
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_cap_nxt = r_aw_cap;
    w_w_cap_nxt  = r_w_cap;
    w_bvalid_nxt = r_bvalid;
    w_bresp_nxt  = r_bresp;
    w_commit     = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs) w_aw_cap_nxt = 1'b1;
        if (w_w_hs)  w_w_cap_nxt  = 1'b1;
        if (w_aw_cap_nxt && w_w_cap_nxt) begin
          w_commit     = 1'b1;
          w_wstate_nxt = W_RESP;
          w_bvalid_nxt = 1'b1;
          w_bresp_nxt  = w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      W_RESP: begin
        if (w_b_hs) begin
          w_wstate_nxt = W_IDLE;
          w_aw_cap_nxt = 1'b0;
          w_w_cap_nxt  = 1'b0;
          w_bvalid_nxt = 1'b0;
        end
      end
      default: w_wstate_nxt = W_IDLE;
    endcase
    w_awready_nxt = (w_wstate_nxt == W_IDLE) && !w_aw_cap_nxt;
    w_wready_nxt  = (w_wstate_nxt == W_IDLE) && !w_w_cap_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate  <= w_rstate_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rresp   <= w_rresp_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_rvalid_nxt = r_rvalid;
    w_rresp_nxt  = r_rresp;
    case (r_rstate)
      R_IDLE: begin
        if (w_ar_hs) begin
          w_rstate_nxt = R_DATA;
          w_rvalid_nxt = 1'b1;
          w_rresp_nxt  = w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
        end
      end
      R_DATA: begin
        if (w_r_hs) begin
          w_rstate_nxt = R_IDLE;
          w_rvalid_nxt = 1'b0;
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
    w_arready_nxt = (w_rstate_nxt == R_IDLE);
  end

  axi4lite_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .MEM_AW     (MEM_AW)
  ) u_bram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_commit & w_wr_in_range & ~rst),
    .i_waddr (w_wr_idx[MEM_AW-1:0]),
    .i_wdata (w_wr_data),
    .i_wstrb (w_wr_strb),
    .i_re    (w_ar_hs),
    .i_rzero (~w_rd_in_range),
    .i_raddr (w_rd_idx[MEM_AW-1:0]),
    .o_rdata (w_bram_rdata)
  );

  assign s_axi.awready = r_awready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.arready = r_arready;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rdata   = w_bram_rdata;

endmodule

// File: tb/tb_axi4lite_slave.sv
// Self-checking bench for axi4lite_slave: scoreboard queues of expected
// B and R responses, filled at stimulus time and drained at handshakes.
module tb_axi4lite_slave;
  import axi4lite_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4lite_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .s_axi (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  exp_b_q [$];
  rexp_t       exp_r_q [$];
  logic [31:0] model_mem [int unsigned];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] resp_for(input logic [31:0] addr);
    return ((addr >> 2) < DEPTH) ? RESP_OKAY : RESP_SLVERR;
  endfunction

  function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                      input logic [3:0] strb);
    int unsigned idx = addr >> 2;
    logic [31:0] w;
    if (idx >= DEPTH) return;
    w = model_mem.exists(idx) ? model_mem[idx] : 32'hx;
    for (int b = 0; b < 4; b++) if (strb[b]) w[b*8 +: 8] = data[b*8 +: 8];
    model_mem[idx] = w;
  endfunction

  function automatic rexp_t model_read(input logic [31:0] addr);
    rexp_t e;
    int unsigned idx = addr >> 2;
    e.resp = resp_for(addr);
    e.data = (idx < DEPTH) ? model_mem[idx] : 32'h0;
    return e;
  endfunction

  task automatic pop_b();
    check_eq("b_q_avail", 64'(exp_b_q.size() != 0), 64'd1);
    if (exp_b_q.size() != 0) check_eq("bresp", 64'(bus.bresp), 64'(exp_b_q.pop_front()));
  endtask

  task automatic pop_r();
    rexp_t e;
    check_eq("r_q_avail", 64'(exp_r_q.size() != 0), 64'd1);
    if (exp_r_q.size() != 0) begin
      e = exp_r_q.pop_front();
      check_eq("rdata", 64'(bus.rdata), 64'(e.data));
      check_eq("rresp", 64'(bus.rresp), 64'(e.resp));
    end
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int lead, input int b_stall);
    bit aw_done = 0;
    bit w_done  = 0;
    int t = 0;
    logic aw_fire, w_fire;
    exp_b_q.push_back(resp_for(addr));
    model_write(addr, data, strb);
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = (lead <= 0);
    bus.wvalid  = (lead >= 0);
    while (!(aw_done && w_done) && t < 30) begin
      aw_fire = bus.awvalid && bus.awready;
      w_fire  = bus.wvalid && bus.wready;
      tick();
      t++;
      if (aw_fire) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (w_fire)  begin w_done  = 1; bus.wvalid  = 1'b0; end
      if (!aw_done && t >= lead)  bus.awvalid = 1'b1;
      if (!w_done  && t >= -lead) bus.wvalid  = 1'b1;
      if (!(aw_done && w_done)) begin
        check_eq("bvalid_early", 64'(bus.bvalid), 64'd0);
        if (w_done)  check_eq("wready_after_w", 64'(bus.wready), 64'd0);
        if (aw_done) check_eq("awready_after_aw", 64'(bus.awready), 64'd0);
      end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check_eq("wr_hs_done", 64'(aw_done && w_done), 64'd1);
    check_eq("b_latency", 64'(bus.bvalid), 64'd1);
    for (int i = 0; i < b_stall; i++) begin
      tick();
      check_eq("b_stall_valid", 64'(bus.bvalid), 64'd1);
      check_eq("b_stall_resp", 64'(bus.bresp), 64'(exp_b_q[0]));
      check_eq("b_stall_awready", 64'(bus.awready), 64'd0);
    end
    bus.bready = 1'b1;
    pop_b();
    tick();
    bus.bready = 1'b0;
    check_eq("bvalid_clear", 64'(bus.bvalid), 64'd0);
    check_eq("awready_back", 64'(bus.awready), 64'd1);
    check_eq("wready_back", 64'(bus.wready), 64'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_stall);
    int t = 0;
    exp_r_q.push_back(model_read(addr));
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!bus.arready && t < 20) begin tick(); t++; end
    check_eq("arready_seen", 64'(bus.arready), 64'd1);
    tick();
    bus.arvalid = 1'b0;
    check_eq("r_latency", 64'(bus.rvalid), 64'd1);
    check_eq("arready_busy", 64'(bus.arready), 64'd0);
    for (int i = 0; i < r_stall; i++) begin
      tick();
      check_eq("r_stall_valid", 64'(bus.rvalid), 64'd1);
      check_eq("r_stall_data", 64'(bus.rdata), 64'(exp_r_q[0].data));
      check_eq("r_stall_resp", 64'(bus.rresp), 64'(exp_r_q[0].resp));
    end
    bus.rready = 1'b1;
    pop_r();
    tick();
    bus.rready = 1'b0;
    check_eq("rvalid_clear", 64'(bus.rvalid), 64'd0);
    check_eq("arready_back", 64'(bus.arready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready  = 1'b0; bus.arvalid = 1'b0; bus.araddr = '0; bus.rready = 1'b0;

    // Reset state then idle readies
    repeat (3) tick();
    check_eq("rst_awready", 64'(bus.awready), 64'd0);
    check_eq("rst_arready", 64'(bus.arready), 64'd0);
    check_eq("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check_eq("rst_rdata", 64'(bus.rdata), 64'd0);
    rst = 1'b0;
    tick();
    check_eq("idle_awready", 64'(bus.awready), 64'd1);
    check_eq("idle_wready", 64'(bus.wready), 64'd1);
    check_eq("idle_arready", 64'(bus.arready), 64'd1);
    check_eq("idle_bvalid", 64'(bus.bvalid), 64'd0);
    check_eq("idle_rvalid", 64'(bus.rvalid), 64'd0);

    // Basic write/read, then strobes with W three cycles ahead of AW
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
    do_read(32'h10, 0);
    do_write(32'h10, 32'h11223344, 4'h5, 3, 0);
    do_read(32'h10, 0);
    check_eq("strobe_model", 64'(model_mem[4]), 64'h0DE22BE44);

    // AW ahead of W, with response backpressure on both channels
    do_write(32'h24, 32'hCAFEF00D, 4'hF, -2, 5);
    do_read(32'h24, 5);

    // Out of range must not alias onto word 0
    do_write(32'h0, 32'hA5A5A5A5, 4'hF, 0, 0);
    do_write(32'h1000, 32'h5A5A5A5A, 4'hF, 0, 0);
    do_read(32'h1000, 0);
    do_read(32'h0, 0);
    do_write(32'h1FFC, 32'h0, 4'hF, 1, 0);

    // Same-cycle read and write commit to one word: read sees old data
    exp_r_q.push_back(model_read(32'h24));
    exp_b_q.push_back(RESP_OKAY);
    model_write(32'h24, 32'h01020304, 4'hF);
    bus.awaddr = 32'h24; bus.wdata = 32'h01020304; bus.wstrb = 4'hF; bus.araddr = 32'h24;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check_eq("conc_bvalid", 64'(bus.bvalid), 64'd1);
    check_eq("conc_rvalid", 64'(bus.rvalid), 64'd1);
    bus.bready = 1'b1; bus.rready = 1'b1;
    pop_b();
    pop_r();
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    do_read(32'h24, 0);

    // Reset with both responses pending drops them; committed data survives
    exp_b_q.push_back(RESP_OKAY);
    exp_r_q.push_back(model_read(32'h10));
    model_write(32'h30, 32'h77665544, 4'hF);
    bus.awaddr = 32'h30; bus.wdata = 32'h77665544; bus.wstrb = 4'hF; bus.araddr = 32'h10;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.arvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    check_eq("pre_rst_bvalid", 64'(bus.bvalid), 64'd1);
    check_eq("pre_rst_rdata", 64'(bus.rdata), 64'(exp_r_q[0].data));
    rst = 1'b1;
    tick();
    check_eq("mid_rst_bvalid", 64'(bus.bvalid), 64'd0);
    check_eq("mid_rst_rvalid", 64'(bus.rvalid), 64'd0);
    check_eq("mid_rst_rdata", 64'(bus.rdata), 64'd0);
    check_eq("mid_rst_awready", 64'(bus.awready), 64'd0);
    void'(exp_b_q.pop_back());
    void'(exp_r_q.pop_back());
    rst = 1'b0;
    tick();
    check_eq("post_rst_awready", 64'(bus.awready), 64'd1);
    check_eq("post_rst_arready", 64'(bus.arready), 64'd1);
    do_read(32'h30, 0);

    // Randomised traffic over a small pre-initialised window
    for (int i = 0; i < 8; i++) do_write(32'h100 + 32'(i * 4), $urandom, 4'hF, 0, 0);
    for (int i = 0; i < 24; i++) begin
      a = 32'h100 + 32'($urandom_range(7, 0) * 4);
      if ($urandom_range(1, 0) == 1)
        do_write(a, $urandom, 4'($urandom_range(15, 0)), $urandom_range(4, 0) - 2,
                 $urandom_range(2, 0));
      else
        do_read(a, $urandom_range(2, 0));
    end

    check_eq("b_q_drained", 64'(exp_b_q.size()), 64'd0);
    check_eq("r_q_drained", 64'(exp_r_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
